// File: rtl/node_phase_ctrl_pkg.sv
// Shared node definitions: over-the-air packet type codes and controller phase encodings.
package node_phase_ctrl_pkg;

    localparam int PKT_W   = 3;
    localparam int PHASE_W = 3;

    // Packet type codes carried in fPktType / mni_pkt_type / tx_pkt_type.
    // Codes 110 and 111 are unused and ignored by the controller.
    typedef enum logic [PKT_W-1:0] {
        PKT_HB        = 3'b000,
        PKT_CH_ANN    = 3'b001,
        PKT_JOIN      = 3'b010,
        PKT_RECLUSTER = 3'b011,
        PKT_TS        = 3'b100,
        PKT_DATA      = 3'b101
    } pkt_type_e;

    // Controller phases, reported directly on the phase output.
    typedef enum logic [PHASE_W-1:0] {
        PH_IDLE      = 3'd0,
        PH_SETUP     = 3'd1,
        PH_CLUSTER   = 3'd2,
        PH_ROLE_EVAL = 3'd3,
        PH_JOIN      = 3'd4,
        PH_WAIT_TS   = 3'd5,
        PH_STEADY    = 3'd6
    } phase_e;

    // True when a received packet code matches the given packet type.
    function automatic logic pkt_is(input logic [PKT_W-1:0] code, input pkt_type_e t);
        return code == t;
    endfunction

endpackage

// File: rtl/tdma_slot_timer.sv
// TDMA slot timer: cycle counter within a slot and slot counter within a frame.
// Both counters sit at zero while run is low, so raising run starts a fresh frame.
module tdma_slot_timer #(
    parameter int SLOT_CYCLES = 16,
    parameter int NUM_SLOTS   = 8,
    parameter int SW          = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          run,
    output logic [SW-1:0] slot_cnt,
    output logic          slot_start
);

    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

    logic [CW-1:0] cycle_cnt_reg;
    logic [SW-1:0] slot_cnt_reg;

    // Advance cycle count each cycle while running; wrap bumps the slot count modulo NUM_SLOTS.
    always_ff @(posedge clk) begin
        if (nrst || !run) begin
            cycle_cnt_reg <= '0;
            slot_cnt_reg  <= '0;
        end else if (cycle_cnt_reg == CW'(SLOT_CYCLES - 1)) begin
            cycle_cnt_reg <= '0;
            slot_cnt_reg  <= (slot_cnt_reg == SW'(NUM_SLOTS - 1)) ? '0 : slot_cnt_reg + 1'b1;
        end else begin
            cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
        end
    end

    assign slot_cnt   = slot_cnt_reg;
    assign slot_start = run && (cycle_cnt_reg == '0);

endmodule

// File: rtl/node_phase_ctrl.sv
// Node phase controller: walks a sensor node through cluster setup, joining,
// slot assignment and steady-state TDMA transmission.
module node_phase_ctrl
    import node_phase_ctrl_pkg::*;
#(
    parameter int SLOT_CYCLES = 16,
    parameter int NUM_SLOTS   = 8,
    parameter int TS_TIMEOUT  = 4096
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        start,
    input  logic        pkt_valid,
    input  logic [2:0]  fPktType,
    input  logic        role,
    input  logic        low_E,
    input  logic [15:0] timeslot,
    input  logic        data_pending,
    input  logic        tx_ack,
    output logic        en_MNI,
    output logic [2:0]  mni_pkt_type,
    output logic        tx_req,
    output logic [2:0]  tx_pkt_type,
    output logic [2:0]  phase,
    output logic        slot_miss
);

    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int TW = $clog2(TS_TIMEOUT + 1);

    phase_e         state_reg, state_next;
    logic           en_mni_reg, en_mni_next;
    logic [2:0]     mni_type_reg, mni_type_next;
    logic           tx_req_reg, tx_req_next;
    logic [2:0]     tx_type_reg, tx_type_next;
    logic           slot_miss_reg, slot_miss_next;
    logic [TW-1:0]  to_cnt_reg, to_cnt_next;
    logic           low_e_reg;

    logic           in_steady;
    logic [SW-1:0]  slot_cnt;
    logic           slot_start;
    logic [SW-1:0]  own_slot;
    logic           own_start;
    logic           pkt_ok;
    logic           ack_ok;
    logic           low_e_rise;

    assign in_steady  = (state_reg == PH_STEADY);
    assign own_slot   = SW'(timeslot % 16'(NUM_SLOTS));
    assign own_start  = slot_start && (slot_cnt == own_slot);
    // A packet arriving while the previous strobe is still out is dropped so
    // en_MNI can never stay high for two cycles in a row.
    assign pkt_ok     = pkt_valid && !en_mni_reg;
    // An acknowledge only counts against an outstanding request.
    assign ack_ok     = tx_ack && tx_req_reg;
    assign low_e_rise = low_E && !low_e_reg;

    tdma_slot_timer #(
        .SLOT_CYCLES (SLOT_CYCLES),
        .NUM_SLOTS   (NUM_SLOTS),
        .SW          (SW)
    ) u_slot_timer (
        .clk        (clk),
        .nrst       (nrst),
        .run        (in_steady),
        .slot_cnt   (slot_cnt),
        .slot_start (slot_start)
    );

    // State, strobe, request and edge-detect registers.
    always_ff @(posedge clk) begin
        if (nrst) begin
            state_reg     <= PH_IDLE;
            en_mni_reg    <= 1'b0;
            mni_type_reg  <= PKT_HB;
            tx_req_reg    <= 1'b0;
            tx_type_reg   <= PKT_HB;
            slot_miss_reg <= 1'b0;
            to_cnt_reg    <= '0;
            low_e_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            en_mni_reg    <= en_mni_next;
            mni_type_reg  <= mni_type_next;
            tx_req_reg    <= tx_req_next;
            tx_type_reg   <= tx_type_next;
            slot_miss_reg <= slot_miss_next;
            to_cnt_reg    <= to_cnt_next;
            low_e_reg     <= low_E;
        end
    end

    // Next-state and output decisions for every phase.
    always_comb begin
        state_next     = state_reg;
        en_mni_next    = 1'b0;
        mni_type_next  = mni_type_reg;
        tx_req_next    = tx_req_reg;
        tx_type_next   = tx_type_reg;
        slot_miss_next = 1'b0;
        to_cnt_next    = '0;

        // The transmitter consumed the pending request, whatever phase we are in.
        if (ack_ok) begin
            tx_req_next = 1'b0;
        end

        case (state_reg)
            PH_IDLE: begin
                if (start) begin
                    state_next = PH_SETUP;
                end
            end

            PH_SETUP: begin
                if (pkt_ok && pkt_is(fPktType, PKT_HB)) begin
                    en_mni_next   = 1'b1;
                    mni_type_next = PKT_HB;
                    state_next    = PH_CLUSTER;
                end
            end

            PH_CLUSTER: begin
                if (pkt_ok && pkt_is(fPktType, PKT_CH_ANN)) begin
                    en_mni_next   = 1'b1;
                    mni_type_next = PKT_CH_ANN;
                    state_next    = PH_ROLE_EVAL;
                end
            end

            PH_ROLE_EVAL: begin
                // Cluster heads skip straight to steady state; members must join.
                if (role) begin
                    state_next = PH_STEADY;
                end else begin
                    state_next   = PH_JOIN;
                    tx_req_next  = 1'b1;
                    tx_type_next = PKT_JOIN;
                end
            end

            PH_JOIN: begin
                if (ack_ok) begin
                    state_next = PH_WAIT_TS;
                end
            end

            PH_WAIT_TS: begin
                if (pkt_ok && pkt_is(fPktType, PKT_TS)) begin
                    en_mni_next   = 1'b1;
                    mni_type_next = PKT_TS;
                    state_next    = PH_STEADY;
                end else if (to_cnt_reg == TW'(TS_TIMEOUT - 1)) begin
                    state_next = PH_SETUP;
                end else begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end
            end

            PH_STEADY: begin
                if (pkt_ok && pkt_is(fPktType, PKT_DATA)) begin
                    en_mni_next   = 1'b1;
                    mni_type_next = PKT_DATA;
                end else if (pkt_ok && pkt_is(fPktType, PKT_HB)) begin
                    en_mni_next   = 1'b1;
                    mni_type_next = PKT_HB;
                    state_next    = PH_CLUSTER;
                end

                if (ack_ok && (tx_type_reg == PKT_RECLUSTER)) begin
                    // Recluster request sent: restart the setup round.
                    state_next = PH_SETUP;
                end else if (low_e_rise) begin
                    // Energy dropped: recluster request displaces any data request.
                    tx_req_next  = 1'b1;
                    tx_type_next = PKT_RECLUSTER;
                    if (own_start && tx_req_reg) begin
                        slot_miss_next = 1'b1;
                    end
                end else if (own_start) begin
                    if (tx_req_reg) begin
                        slot_miss_next = 1'b1;
                    end else if (data_pending) begin
                        tx_req_next  = 1'b1;
                        tx_type_next = PKT_DATA;
                    end
                end
            end

            default: begin
                state_next = PH_IDLE;
            end
        endcase
    end

    assign en_MNI       = en_mni_reg;
    assign mni_pkt_type = mni_type_reg;
    assign tx_req       = tx_req_reg;
    assign tx_pkt_type  = tx_type_reg;
    assign phase        = state_reg;
    assign slot_miss    = slot_miss_reg;

endmodule

// File: tb/tb_node_phase_ctrl.sv
// Directed walk through the node phases with randomized slot numbers, packet
// mixes and gaps; expectations come from frame/slot arithmetic in the bench.
module tb_node_phase_ctrl;
    import node_phase_ctrl_pkg::*;

    localparam int SC    = 16;
    localparam int NS    = 8;
    localparam int TO    = 4096;
    localparam int FRAME = SC * NS;

    logic        clk;
    logic        nrst;
    logic        start;
    logic        pkt_valid;
    logic [2:0]  fPktType;
    logic        role;
    logic        low_E;
    logic [15:0] timeslot;
    logic        data_pending;
    logic        tx_ack;
    logic        en_MNI;
    logic [2:0]  mni_pkt_type;
    logic        tx_req;
    logic [2:0]  tx_pkt_type;
    logic [2:0]  phase;
    logic        slot_miss;

    int n_tests = 0;
    int n_fail  = 0;
    int k_st    = 0;   // cycles since the current STEADY entry

    node_phase_ctrl #(
        .SLOT_CYCLES (SC),
        .NUM_SLOTS   (NS),
        .TS_TIMEOUT  (TO)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .start        (start),
        .pkt_valid    (pkt_valid),
        .fPktType     (fPktType),
        .role         (role),
        .low_E        (low_E),
        .timeslot     (timeslot),
        .data_pending (data_pending),
        .tx_ack       (tx_ack),
        .en_MNI       (en_MNI),
        .mni_pkt_type (mni_pkt_type),
        .tx_req       (tx_req),
        .tx_pkt_type  (tx_pkt_type),
        .phase        (phase),
        .slot_miss    (slot_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        k_st++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_pkt(input logic [2:0] t);
        pkt_valid = 1'b1;
        fPktType  = t;
        tick();
        pkt_valid = 1'b0;
        fPktType  = 3'b000;
    endtask

    task automatic pulse_ack();
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
    endtask

    initial begin
        int own;
        int own2;
        int w;
        int n;
        int en_seen;
        int s;
        int k0;
        logic [2:0] t;

        nrst = 1'b1; start = 1'b0; pkt_valid = 1'b0; fPktType = 3'b000;
        role = 1'b0; low_E = 1'b0; timeslot = 16'd3; data_pending = 1'b0; tx_ack = 1'b0;

        repeat (3) tick();
        chk("rst_phase", phase, PH_IDLE);
        chk("rst_en_mni", en_MNI, 0);
        chk("rst_tx_req", tx_req, 0);
        chk("rst_tx_type", tx_pkt_type, 0);
        chk("rst_mni_type", mni_pkt_type, 0);
        chk("rst_slot_miss", slot_miss, 0);
        nrst = 1'b0;
        tick();
        chk("idle_hold", phase, PH_IDLE);

        // Setup round as in the reference scenario: HB, CH_ANN, role=0, ack, TS slot 3.
        start = 1'b1;
        tick();
        chk("start_setup", phase, PH_SETUP);
        start = 1'b0;
        tick();
        chk("start_drop_no_effect", phase, PH_SETUP);

        send_pkt(PKT_DATA);
        chk("setup_ignore_data_en", en_MNI, 0);
        chk("setup_ignore_data_ph", phase, PH_SETUP);
        tick();

        send_pkt(PKT_HB);
        chk("hb_en", en_MNI, 1);
        chk("hb_type", mni_pkt_type, PKT_HB);
        chk("hb_phase", phase, PH_CLUSTER);
        tick();
        chk("hb_en_single", en_MNI, 0);

        send_pkt(PKT_CH_ANN);
        chk("chann_en", en_MNI, 1);
        chk("chann_type", mni_pkt_type, PKT_CH_ANN);
        chk("chann_phase", phase, PH_ROLE_EVAL);
        tick();
        chk("role_eval_one_cycle", phase, PH_JOIN);
        chk("join_req", tx_req, 1);
        chk("join_type", tx_pkt_type, PKT_JOIN);
        repeat ($urandom_range(1, 5)) tick();
        chk("join_req_held", tx_req, 1);
        pulse_ack();
        chk("join_ack_phase", phase, PH_WAIT_TS);
        chk("join_ack_req", tx_req, 0);

        data_pending = 1'b1;
        repeat ($urandom_range(2, 10)) tick();
        send_pkt(PKT_TS);
        k_st = 0;
        chk("ts_en", en_MNI, 1);
        chk("ts_type", mni_pkt_type, PKT_TS);
        chk("ts_phase", phase, PH_STEADY);

        // Own slot 3 starts 3*SC cycles into the frame; the request shows one cycle later.
        own = 3;
        w = 0;
        while (tx_req !== 1'b1 && w < 400) begin
            tick();
            w++;
        end
        chk("data_req_time", k_st, own * SC + 1);
        chk("data_req_type", tx_pkt_type, PKT_DATA);

        // Leave the request unacknowledged for a full frame.
        w = 0;
        while (slot_miss !== 1'b1 && w < 400) begin
            tick();
            w++;
        end
        chk("slot_miss_time", k_st, own * SC + FRAME + 1);
        chk("slot_miss_req_held", tx_req, 1);
        tick();
        chk("slot_miss_pulse", slot_miss, 0);

        // Acknowledge and receive DATA in the same cycle.
        tx_ack = 1'b1; pkt_valid = 1'b1; fPktType = PKT_DATA;
        tick();
        tx_ack = 1'b0; pkt_valid = 1'b0; fPktType = 3'b000;
        chk("ack_pkt_req", tx_req, 0);
        chk("ack_pkt_en", en_MNI, 1);
        chk("ack_pkt_type", mni_pkt_type, PKT_DATA);
        tick();
        chk("ack_pkt_en_single", en_MNI, 0);

        pulse_ack();
        chk("stray_ack_req", tx_req, 0);
        chk("stray_ack_phase", phase, PH_STEADY);

        // low_E rises exactly at own-slot start with data pending: recluster wins.
        w = 0;
        while ((k_st % FRAME) != own * SC && w < 400) begin
            tick();
            w++;
        end
        low_E = 1'b1;
        tick();
        chk("lowe_req", tx_req, 1);
        chk("lowe_type", tx_pkt_type, PKT_RECLUSTER);
        chk("lowe_no_miss", slot_miss, 0);
        repeat ($urandom_range(1, 8)) tick();
        chk("lowe_type_held", tx_pkt_type, PKT_RECLUSTER);
        pulse_ack();
        chk("lowe_ack_phase", phase, PH_SETUP);
        chk("lowe_ack_req", tx_req, 0);
        low_E = 1'b0;
        data_pending = 1'b0;
        tick();

        // Cluster-head path straight to STEADY, random slot number.
        send_pkt(PKT_HB);
        chk("ch_hb_phase", phase, PH_CLUSTER);
        tick();
        role = 1'b1;
        timeslot = 16'($urandom);
        own2 = int'(timeslot) % NS;
        send_pkt(PKT_CH_ANN);
        chk("ch_eval_phase", phase, PH_ROLE_EVAL);
        tick();
        k_st = 0;
        chk("ch_steady", phase, PH_STEADY);
        chk("ch_no_req", tx_req, 0);

        for (int i = 0; i < 6; i++) begin
            t = 3'($urandom_range(1, 7));
            send_pkt(t);
            chk("steady_pkt_en", en_MNI, (t == 3'b101) ? 1 : 0);
            if (t == 3'b101) chk("steady_pkt_type", mni_pkt_type, PKT_DATA);
            chk("steady_pkt_phase", phase, PH_STEADY);
            tick();
            chk("steady_pkt_en_single", en_MNI, 0);
        end

        data_pending = 1'b1;
        k0 = k_st;
        s = k0;
        while ((s % FRAME) != own2 * SC) s++;
        w = 0;
        while (tx_req !== 1'b1 && w < 400) begin
            tick();
            w++;
        end
        chk("rand_slot_req_time", k_st, s + 1);
        chk("rand_slot_req_type", tx_pkt_type, PKT_DATA);
        data_pending = 1'b0;
        pulse_ack();
        chk("rand_slot_ack", tx_req, 0);
        tick();

        send_pkt(PKT_HB);
        chk("steady_hb_en", en_MNI, 1);
        chk("steady_hb_type", mni_pkt_type, PKT_HB);
        chk("steady_hb_phase", phase, PH_CLUSTER);
        tick();

        // Join again, then let the TS wait expire.
        role = 1'b0;
        send_pkt(PKT_CH_ANN);
        tick();
        chk("rejoin_phase", phase, PH_JOIN);
        pulse_ack();
        chk("wait_ts_phase", phase, PH_WAIT_TS);
        n = 0;
        en_seen = 0;
        while (phase == PH_WAIT_TS && n < TO + 50) begin
            pkt_valid = (n == 100);
            fPktType  = PKT_CH_ANN;
            tick();
            n++;
            if (en_MNI) en_seen++;
        end
        pkt_valid = 1'b0;
        fPktType  = 3'b000;
        chk("timeout_cycles", n, TO);
        chk("timeout_phase", phase, PH_SETUP);
        chk("timeout_no_en", en_seen, 0);

        // Reset while the JOIN request is outstanding.
        send_pkt(PKT_HB);
        tick();
        send_pkt(PKT_CH_ANN);
        tick();
        chk("rst_join_phase", phase, PH_JOIN);
        chk("rst_join_req", tx_req, 1);
        nrst = 1'b1;
        tick();
        chk("rst_mid_phase", phase, PH_IDLE);
        chk("rst_mid_req", tx_req, 0);
        chk("rst_mid_type", tx_pkt_type, 0);
        nrst = 1'b0;
        tick();
        chk("rst_mid_idle", phase, PH_IDLE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/node_phase_ctrl.md
NODE_PHASE_CTRL -- requirements
Module: node_phase_ctrl

Interface
REQ-001 Parameter SLOT_CYCLES, default 16: clock cycles per TDMA slot.
REQ-002 Parameter NUM_SLOTS, default 8: slots per TDMA frame.
REQ-003 Parameter TS_TIMEOUT, default 4096: cycles allowed in WAIT_TS before round abort.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 nrst  input  1  synchronous reset, asserted when 1.
REQ-007 start  input  1  level; begins setup round from IDLE.
REQ-008 pkt_valid  input  1  one-cycle pulse, received packet decoded.
REQ-009 fPktType  input  3  type of received packet, valid with pkt_valid.
REQ-010 role  input  1  node-info role flag, 1 = cluster head.
REQ-011 low_E  input  1  node-info low-energy flag.
REQ-012 timeslot  input  16  assigned slot index from node info.
REQ-013 data_pending  input  1  local data awaiting transmission.
REQ-014 tx_ack  input  1  one-cycle pulse, transmitter consumed request.
REQ-015 en_MNI  output  1  one-cycle update strobe to node-info block.
REQ-016 mni_pkt_type  output  3  packet type presented with en_MNI.
REQ-017 tx_req  output  1  transmit request, held until tx_ack.
REQ-018 tx_pkt_type  output  3  type to transmit, stable while tx_req=1.
REQ-019 phase  output  3  current state encoding.
REQ-020 slot_miss  output  1  one-cycle pulse, own slot passed unserved.

Function
REQ-021 Packet types SHALL be HB=000, CH_ANN=001, JOIN=010, RECLUSTER=011, TS=100, DATA=101; others ignored.
REQ-022 States SHALL be IDLE, SETUP, CLUSTER, ROLE_EVAL, JOIN, WAIT_TS, STEADY.
REQ-023 IDLE->SETUP when start=1.
REQ-024 SETUP: pkt_valid with HB -> en_MNI pulse next cycle, mni_pkt_type=000, go CLUSTER.
REQ-025 CLUSTER: pkt_valid with CH_ANN -> en_MNI pulse (001), go ROLE_EVAL.
REQ-026 ROLE_EVAL SHALL last exactly one cycle, then sample role: 1 -> STEADY, 0 -> JOIN.
REQ-027 JOIN: tx_req=1, tx_pkt_type=010; on tx_ack go WAIT_TS.
REQ-028 WAIT_TS: pkt_valid with TS -> en_MNI pulse (100), go STEADY; TS_TIMEOUT cycles without TS -> SETUP.
REQ-029 en_MNI SHALL be asserted exactly one cycle after the accepted pkt_valid, never two consecutive cycles.
REQ-030 STEADY: cycle_cnt counts 0..SLOT_CYCLES-1; at wrap, slot_cnt increments mod NUM_SLOTS; both cleared on STEADY entry.
REQ-031 Own slot = timeslot mod NUM_SLOTS; at cycle_cnt=0 of own slot with data_pending=1 and tx_req=0 -> tx_req=1, type 101.
REQ-032 Own slot start with tx_req already 1 -> no new request, slot_miss pulse.
REQ-033 STEADY: received DATA -> en_MNI pulse (101); received HB -> en_MNI pulse (000), go CLUSTER.
REQ-034 STEADY: low_E rising edge -> RECLUSTER request (011) replacing any unacknowledged DATA request; on tx_ack go SETUP.
REQ-035 Simultaneous low_E rise and own-slot start: RECLUSTER wins, no DATA request.
REQ-036 tx_ack and pkt_valid in the same cycle SHALL both be processed.
REQ-037 tx_ack while tx_req=0 SHALL be ignored.
REQ-038 start deasserted outside IDLE SHALL have no effect.

Reset
REQ-039 nrst=1 SHALL force IDLE, counters 0, en_MNI=0, tx_req=0, tx_pkt_type=000, mni_pkt_type=000, slot_miss=0, low_E edge register 0.
REQ-040 Reset mid-transmit SHALL drop tx_req the following cycle without waiting for tx_ack.

Structure
REQ-041 Packet-type codes and state encodings SHALL live in the shared node package.
REQ-042 Slot/cycle counting SHALL be one sub-module, tdma_slot_timer.

Verification
REQ-043 start, HB, CH_ANN, role=0, tx_ack, TS timeslot=3 -> en_MNI pulses 000/001/100, JOIN request, STEADY reached.
REQ-044 STEADY, timeslot=3, data_pending=1, defaults -> tx_req type 101 at cycle 48 after STEADY entry.
REQ-045 tx_req held unacked across a full frame -> slot_miss pulse at next own-slot start.
REQ-046 low_E rises at own-slot start -> tx_pkt_type=011, SETUP after tx_ack.
REQ-047 WAIT_TS with no TS for 4096 cycles -> SETUP, no en_MNI.
REQ-048 nrst during JOIN with tx_req=1 -> IDLE, tx_req=0 next cycle.
